sync_fifo_ctrl: RTL and testbench
=================================

Name: sync_fifo_ctrl

Overview:
Parametrised single-clock FIFO with programmable almost-full/almost-empty thresholds, an occupancy count and error pulses.
Successor to the basic w_en/r_en FIFO; uses the same write/read handshake so existing driver/monitor stimulus carries over.
Sits between a producer and a consumer in one clock domain.
Optional first-word-fall-through (FWFT) read mode.

Parameters:
DATA_WIDTH, 8, width of data_in/data_out
DEPTH, 16, number of entries; power of two, minimum 4
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH
AW (localparam), $clog2(DEPTH), pointer width

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  asynchronous, active-low reset
w_en  input  1  write request
r_en  input  1  read request
data_in  input  DATA_WIDTH  write data
data_out  output  DATA_WIDTH  read data
full  output  1  count == DEPTH
empty  output  1  no word available to read
almost_full  output  1  count >= AF_THRESH
almost_empty  output  1  count <= AE_THRESH
count  output  AW+1  current occupancy, 0..DEPTH
overflow  output  1  one-cycle pulse: write rejected
underflow  output  1  one-cycle pulse: read rejected

Behaviour:
- Reset (rst low, asynchronous): wr_ptr, rd_ptr and count go to 0.
  - Output reset values: data_out=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
  - The storage array is not reset.
- Write accept: wr_acc = w_en && !full. Stores data_in at wr_ptr; wr_ptr increments modulo DEPTH.
- Read accept: rd_acc = r_en && !empty.
  - Standard mode: data_out <= mem[rd_ptr] on the same edge (one-cycle read latency); rd_ptr increments modulo DEPTH.
  - data_out holds its value when no read is accepted.
- Pointers are AW bits and wrap naturally. full/empty derive from count; no pointer-MSB comparison.
- count update:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged on both or neither.
- Simultaneous w_en and r_en:
  - Both accepted when 0 < count < DEPTH.
  - When full: write rejected (overflow pulses), read accepted.
  - When empty: read rejected (underflow pulses), write accepted.
  - No pass-through.
- overflow = registered (w_en && full). underflow = registered (r_en && empty). Both are high for exactly the cycle after the offending request.
- All flags (full, empty, almost_*) are registered and consistent with count in the same cycle.
- Reset mid-operation: all contents are discarded. The first accepted write after rst deasserts is the first word read out.
- Illegal parameters (AE_THRESH >= AF_THRESH, DEPTH not a power of two): elaboration-time $error.

Optional Feature:
Macro SYNC_FIFO_FWFT_EN.
- Defined:
  - A one-entry output register holds the head word. data_out is valid whenever empty=0, with no read latency.
  - rd_acc consumes the presented word. The next word (or a word written while the FIFO is empty) appears one cycle later.
  - count includes the output register.
  - empty deasserts two cycles after the first write into an empty FIFO: one cycle into memory, one into the output register.
- Not defined: standard one-cycle-latency behaviour as above.

Decomposition:
- Package sync_fifo_pkg:
  - Function for pointer increment with wrap.
  - Default DATA_WIDTH/DEPTH constants.
  - Typedef for count width helper.
- One sub-module, sync_fifo_mem: simple dual-port register array, write port plus asynchronous read address, no reset.
- Control, flags and the FWFT stage stay in sync_fifo_ctrl.

Test Plan (DEPTH=8, DATA_WIDTH=8, AF_THRESH=6, AE_THRESH=2):
- Reset, then write 0x01..0x08 -> full=1 after 8th write, count=8; almost_full rises when count reaches 6; a 9th write gives overflow=1 for one cycle and count stays 8.
- From full, read 8 times -> data_out 0x01..0x08 in order, each one cycle after r_en; empty=1 after the last; almost_empty rises at count=2.
- Empty FIFO, r_en=1 -> underflow=1 for one cycle; data_out unchanged; count=0.
- Fill to 4, then 20 cycles of simultaneous w_en/r_en with incrementing data -> count stays 4; output order preserved across pointer wrap.
- Full FIFO, w_en=r_en=1 -> read accepted, write rejected; overflow pulses; count=7.
- Fill to 5, assert rst low mid-cycle -> outputs immediately return to reset values; after release, write 0xAA then read -> data_out=0xAA.
- With SYNC_FIFO_FWFT_EN, write 0x55 to empty FIFO -> empty falls two cycles later with data_out=0x55 already present; r_en that cycle -> empty=1 next cycle.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the sync_fifo_ctrl FIFO.
// Default sizes, pointer wrap and count-width helpers.
package sync_fifo_pkg;

    localparam int unsigned DefDataWidth = 8;
    localparam int unsigned DefDepth     = 16;

    // Count of a default-sized FIFO; one bit wider than the pointer to hold DEPTH.
    typedef logic [$clog2(DefDepth):0] def_count_t;

    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port register array for sync_fifo_ctrl: one write port and an
// asynchronous read address. Contents are intentionally not reset.
module sync_fifo_mem #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]         i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with occupancy count, almost-full/empty flags and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads via a head register.
module sync_fifo_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned DEPTH      = DefDepth,
    parameter int unsigned AF_THRESH  = DEPTH - 2,
    parameter int unsigned AE_THRESH  = 2,
    localparam int unsigned AW        = $clog2(DEPTH),
    localparam int unsigned CW        = cnt_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_en,
    input  logic                  r_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] LP_AF    = CW'(AF_THRESH);
    localparam logic [CW-1:0] LP_AE    = CW'(AE_THRESH);

    if (AE_THRESH >= AF_THRESH) begin : g_bad_thresh
        $error("sync_fifo_ctrl: AE_THRESH must be below AF_THRESH");
    end
    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo_ctrl: DEPTH must be a power of two, at least 4");
    end

    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_pop;
    logic                  w_empty_d;
    logic [CW-1:0]         w_count_d;
    logic [DATA_WIDTH-1:0] w_rdata;

    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_af;
    logic                  r_ae;
    logic                  r_ovf;
    logic                  r_udf;

    assign w_wr_acc = w_en && !r_full;
    assign w_rd_acc = r_en && !r_empty;

    always_comb begin
        w_count_d = r_count;
        if (w_wr_acc && !w_rd_acc) begin
            w_count_d = r_count + CW'(1);
        end else if (!w_wr_acc && w_rd_acc) begin
            w_count_d = r_count - CW'(1);
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // r_mcnt tracks words still in the array; the head register holds one more.
    logic [CW-1:0] r_mcnt;
    logic [CW-1:0] w_mcnt_d;
    logic          r_hvld;
    logic          w_hvld_d;

    assign w_pop = (!r_hvld || w_rd_acc) && (r_mcnt != '0);

    always_comb begin
        w_mcnt_d = r_mcnt;
        if (w_wr_acc && !w_pop) begin
            w_mcnt_d = r_mcnt + CW'(1);
        end else if (!w_wr_acc && w_pop) begin
            w_mcnt_d = r_mcnt - CW'(1);
        end
        w_hvld_d = r_hvld;
        if (w_pop) begin
            w_hvld_d = 1'b1;
        end else if (w_rd_acc) begin
            w_hvld_d = 1'b0;
        end
    end

    assign w_empty_d = !w_hvld_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mcnt <= '0;
            r_hvld <= 1'b0;
        end else begin
            r_mcnt <= w_mcnt_d;
            r_hvld <= w_hvld_d;
        end
    end
`else
    assign w_pop     = w_rd_acc;
    assign w_empty_d = (w_count_d == '0);
`endif

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (data_in),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    // Flags are computed from next-state count so they line up with count each cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dout   <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_af     <= 1'b0;
            r_ae     <= 1'b1;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= AW'(ptr_inc(32'(r_wr_ptr), DEPTH));
            end
            if (w_pop) begin
                r_rd_ptr <= AW'(ptr_inc(32'(r_rd_ptr), DEPTH));
                r_dout   <= w_rdata;
            end
            r_count <= w_count_d;
            r_full  <= (w_count_d == LP_DEPTH);
            r_empty <= w_empty_d;
            r_af    <= (w_count_d >= LP_AF);
            r_ae    <= (w_count_d <= LP_AE);
            r_ovf   <= w_en && r_full;
            r_udf   <= r_en && r_empty;
        end
    end

    assign data_out     = r_dout;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_af;
    assign almost_empty = r_ae;
    assign count        = r_count;
    assign overflow     = r_ovf;
    assign underflow    = r_udf;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl (DEPTH=8, DATA_WIDTH=8, AF=6, AE=2).
// A queue-based reference model predicts every output after each clock edge.
module tb_sync_fifo_ctrl;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AFT   = 6;
    localparam int unsigned AET   = 2;

    logic          clk;
    logic          rst;
    logic          w_en;
    logic          r_en;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [3:0]    count;
    logic          overflow;
    logic          underflow;

    int unsigned n_total;
    int unsigned n_pass;

    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_dout;
    logic          m_ovf;
    logic          m_udf;

    sync_fifo_ctrl #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AF_THRESH  (AFT),
        .AE_THRESH  (AET)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .w_en         (w_en),
        .r_en         (r_en),
        .data_in      (data_in),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_dout = '0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    // FIFO semantics: a read pops the oldest word, a write appends if there is room.
    task automatic model_edge(input logic w, input logic r, input logic [DW-1:0] d);
        int n;
        n     = m_q.size();
        m_ovf = w && (n == DEPTH);
        m_udf = r && (n == 0);
        if (r && n > 0) m_dout = m_q.pop_front();
        if (w && n < DEPTH) m_q.push_back(d);
    endtask

    task automatic check_all();
        int n;
        n = m_q.size();
        check("data_out", 32'(data_out), 32'(m_dout));
        check("count", 32'(count), n);
        check("full", 32'(full), 32'(n == DEPTH));
        check("empty", 32'(empty), 32'(n == 0));
        check("almost_full", 32'(almost_full), 32'(n >= AFT));
        check("almost_empty", 32'(almost_empty), 32'(n <= AET));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_udf));
    endtask

    task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d);
        w_en    = w;
        r_en    = r;
        data_in = d;
        @(posedge clk);
        model_edge(w, r, d);
        #1;
        check_all();
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst     = 1'b0;
        w_en    = 1'b0;
        r_en    = 1'b0;
        data_in = '0;
        model_reset();
        #12;
`ifdef SYNC_FIFO_FWFT_EN
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        w_en    = 1'b1;
        data_in = 8'h55;
        @(posedge clk);
        #1;
        w_en = 1'b0;
        check("fwft_empty_c1", 32'(empty), 32'd1);
        check("fwft_count_c1", 32'(count), 32'd1);
        @(posedge clk);
        #1;
        check("fwft_empty_c2", 32'(empty), 32'd0);
        check("fwft_data_c2", 32'(data_out), 32'h55);
        r_en = 1'b1;
        @(posedge clk);
        #1;
        r_en = 1'b0;
        check("fwft_empty_c3", 32'(empty), 32'd1);
        check("fwft_count_c3", 32'(count), 32'd0);
`else
        check_all();
        @(negedge clk);
        rst = 1'b1;
        #1;

        // Fill to full, then one rejected write.
        for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 8'(i));
        cycle(1'b1, 1'b0, 8'h99);
        cycle(1'b0, 1'b0, 8'h00);

        // Drain in order, then a rejected read.
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);

        // Steady occupancy of 4 across pointer wrap.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'(8'h10 + i));
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 8'(8'h20 + i));

        // Full with simultaneous write and read.
        while (m_q.size() < DEPTH) cycle(1'b1, 1'b0, 8'($urandom));
        cycle(1'b1, 1'b1, 8'hEE);
        cycle(1'b0, 1'b0, 8'h00);

        // Randomized traffic with write-heavy, balanced and read-heavy phases.
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 150; i++) begin
                cycle(1'($urandom_range(0, 99) < 70 - 20 * p),
                      1'($urandom_range(0, 99) < 30 + 20 * p),
                      8'($urandom));
            end
        end

        // Asynchronous reset mid-operation with 5 words held.
        while (m_q.size() > 0) cycle(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'(8'h40 + i));
        w_en = 1'b0;
        r_en = 1'b0;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b1;
        #1;
        cycle(1'b1, 1'b0, 8'hAA);
        cycle(1'b0, 1'b1, 8'h00);
        check("post_rst_data", 32'(data_out), 32'hAA);
        cycle(1'b0, 1'b0, 8'h00);
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
